// File: rtl/demux_rr_dispatch_if.sv
// Handshake bundle between the round-robin dispatcher and its producer/consumers.
// The slave view belongs to the dispatcher; the master view belongs to the environment.
interface demux_rr_dispatch_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 2,
    parameter int SEL_W  = 1,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0]       in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;
    logic [SEL_W-1:0]        s;
    logic [CNT_W-1:0]        dispatched;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, s, dispatched
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, s, dispatched
    );
endinterface

// File: rtl/demux_rr_dispatch.sv
// Round-robin dispatcher: steers a single valid/ready stream into N_OUT one-entry
// channel buffers in strict order, exporting the select pointer and a word counter.
module demux_rr_chan #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              unload,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full
);
    // Load wins over unload so a same-cycle swap keeps the buffer full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            dout <= '0;
        end else if (clr) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (unload) begin
            full <= 1'b0;
        end
    end
endmodule

module demux_rr_dispatch #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 2,
    parameter int SEL_W  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    demux_rr_dispatch_if.slave   bus
);
    logic [SEL_W-1:0]             s_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [N_OUT-1:0]             sel_oh;
    logic [N_OUT-1:0]             full;
    logic [N_OUT-1:0]             load;
    logic [N_OUT-1:0]             unload;
    logic [N_OUT-1:0][DATA_W-1:0] word_q;
    logic                         tgt_open;
    logic                         in_xfer;

    for (genvar k = 0; k < N_OUT; k++) begin : g_ch
        assign sel_oh[k] = (s_q == SEL_W'(k));
        assign load[k]   = in_xfer & sel_oh[k];
        assign unload[k] = full[k] & bus.out_ready[k];

        demux_rr_chan #(.DATA_W(DATA_W)) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clr),
            .load   (load[k]),
            .unload (unload[k]),
            .din    (bus.in_data),
            .dout   (word_q[k]),
            .full   (full[k])
        );
    end

    // Only the current target matters: no skipping past a stalled channel.
    assign tgt_open     = |(sel_oh & (~full | bus.out_ready));
    assign bus.in_ready = !clr & rst_n & tgt_open;
    assign in_xfer      = bus.in_valid & bus.in_ready;

    assign bus.out_data   = word_q;
    assign bus.out_valid  = full;
    assign bus.s          = s_q;
    assign bus.dispatched = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            s_q   <= '0;
            cnt_q <= '0;
        end else if (in_xfer) begin
            s_q   <= (s_q == SEL_W'(N_OUT - 1)) ? '0 : s_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Scoreboard bench: per-channel expected-word queues fed by observed input
// transfers, checked by a mid-cycle monitor against every DUT output.
module tb_demux_rr_dispatch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_a = 1'b0;
    logic clr_b = 1'b0;

    always #5 clk = ~clk;

    demux_rr_dispatch_if #(.DATA_W(8), .N_OUT(2), .SEL_W(1), .CNT_W(16)) a_if ();
    demux_rr_dispatch_if #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .CNT_W(2))  b_if ();

    demux_rr_dispatch #(.DATA_W(8), .N_OUT(2), .SEL_W(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr_a), .bus(a_if.slave)
    );
    demux_rr_dispatch #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr_b), .bus(b_if.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for DUT A: words accepted so far, and what each channel holds.
    logic [7:0] qa [2][$];
    logic [7:0] last_a [2];
    int         acc_a = 0;

    always @(negedge clk) begin : mon_a
        int tgt;
        if (!rst_n) begin
            chk("rst_in_ready", 32'(a_if.in_ready), 0);
            chk("rst_s", 32'(a_if.s), 0);
            chk("rst_out_valid", 32'(a_if.out_valid), 0);
            chk("rst_out_data", 32'(a_if.out_data), 0);
            chk("rst_dispatched", 32'(a_if.dispatched), 0);
            for (int k = 0; k < 2; k++) begin
                qa[k].delete();
                last_a[k] = 8'h00;
            end
            acc_a = 0;
        end else begin
            tgt = acc_a % 2;
            chk("s", 32'(a_if.s), 32'(tgt));
            chk("dispatched", 32'(a_if.dispatched), 32'(acc_a % 65536));
            for (int k = 0; k < 2; k++) begin
                chk("out_valid", 32'(a_if.out_valid[k]), 32'(qa[k].size() != 0));
                chk("out_data", 32'(a_if.out_data[k*8 +: 8]),
                    32'((qa[k].size() != 0) ? qa[k][0] : last_a[k]));
            end
            chk("in_ready", 32'(a_if.in_ready),
                32'(!clr_a && (qa[tgt].size() == 0 || a_if.out_ready[tgt])));
            if (clr_a) begin
                for (int k = 0; k < 2; k++) begin
                    qa[k].delete();
                    last_a[k] = 8'h00;
                end
                acc_a = 0;
            end else begin
                for (int k = 0; k < 2; k++)
                    if (qa[k].size() != 0 && a_if.out_ready[k]) void'(qa[k].pop_front());
                if (a_if.in_valid && a_if.in_ready) begin
                    qa[tgt].push_back(a_if.in_data);
                    last_a[tgt] = a_if.in_data;
                    acc_a++;
                end
            end
        end
    end

    logic [7:0] t1 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    initial begin
        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = '0;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        tick();

        // back-to-back stream with both consumers always ready
        a_if.out_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            a_if.in_valid = 1'b1;
            a_if.in_data  = t1[i];
            chk("t1_in_ready", 32'(a_if.in_ready), 1);
            tick();
        end
        a_if.in_valid = 1'b0;
        chk("t1_dispatched", 32'(a_if.dispatched), 4);
        tick();

        // strict-order stall
        a_if.out_ready = 2'b00;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 8'h11; tick();
        a_if.in_data   = 8'h22; tick();
        a_if.in_data   = 8'h33; tick();
        chk("t2_stall_ready", 32'(a_if.in_ready), 0);
        chk("t2_stall_s", 32'(a_if.s), 0);
        a_if.out_ready = 2'b10;
        tick();
        chk("t2_ch1_only_ready", 32'(a_if.in_ready), 0);
        tick();
        a_if.out_ready = 2'b11;
        #1 chk("t2_release_ready", 32'(a_if.in_ready), 1);
        tick();
        a_if.in_valid = 1'b0;
        chk("t2_swap_valid", 32'(a_if.out_valid[0]), 1);
        chk("t2_swap_data", 32'(a_if.out_data[7:0]), 32'h33);

        // backpressure hold on ch1
        a_if.out_ready = 2'b00;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 8'h5A;
        tick();
        a_if.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 32'(a_if.out_valid[1]), 1);
            chk("t3_hold_data", 32'(a_if.out_data[15:8]), 32'h5A);
            tick();
        end
        a_if.out_ready = 2'b11;
        tick();

        // clear with both buffers full and a word offered
        a_if.out_ready = 2'b00;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 8'h01; tick();
        a_if.in_data   = 8'h02; tick();
        a_if.in_data   = 8'h03;
        clr_a = 1'b1;
        #1 chk("t4_clr_ready", 32'(a_if.in_ready), 0);
        tick();
        clr_a = 1'b0;
        a_if.in_valid = 1'b0;
        chk("t4_valid", 32'(a_if.out_valid), 0);
        chk("t4_s", 32'(a_if.s), 0);
        chk("t4_dispatched", 32'(a_if.dispatched), 0);

        // asynchronous reset between edges
        a_if.out_ready = 2'b11;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 8'h44; tick();
        a_if.in_data   = 8'h55; tick();
        a_if.in_valid  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(a_if.out_valid), 0);
        chk("t5_data", 32'(a_if.out_data), 0);
        chk("t5_s", 32'(a_if.s), 0);
        chk("t5_dispatched", 32'(a_if.dispatched), 0);
        chk("t5_ready", 32'(a_if.in_ready), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        a_if.out_ready = 2'b00;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 8'h77;
        tick();
        a_if.in_valid = 1'b0;
        chk("t5_first_valid", 32'(a_if.out_valid), 32'b01);
        chk("t5_first_data", 32'(a_if.out_data[7:0]), 32'h77);
        tick();

        // randomized traffic, occasional clear
        for (int i = 0; i < 400; i++) begin
            a_if.in_valid  = 1'($urandom);
            a_if.in_data   = 8'($urandom);
            a_if.out_ready = 2'($urandom);
            clr_a          = ($urandom_range(0, 39) == 0);
            tick();
        end
        clr_a = 1'b0;
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 2'b11;
        repeat (2) tick();

        // three channels, 2-bit counter wrap
        b_if.out_ready = 3'b111;
        for (int i = 0; i < 5; i++) begin
            b_if.in_valid = 1'b1;
            b_if.in_data  = 8'h30 + 8'(i);
            @(negedge clk);
            chk("t6_s", 32'(b_if.s), 32'(i % 3));
            chk("t6_dispatched", 32'(b_if.dispatched), 32'(i % 4));
            chk("t6_in_ready", 32'(b_if.in_ready), 1);
            tick();
            chk("t6_valid", 32'(b_if.out_valid[i % 3]), 1);
            chk("t6_data", 32'(b_if.out_data[(i % 3)*8 +: 8]), 32'(8'h30 + 8'(i)));
        end
        b_if.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_final_s", 32'(b_if.s), 2);
        chk("t6_final_dispatched", 32'(b_if.dispatched), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
